// File: rtl/fx2_pkg.sv
// fx2_pkg: shared definitions for the FX2 slave-FIFO master.
//   EP2_ADDR / EP6_ADDR : FIFOADR codes for the OUT (host->FPGA) and IN
//                         (FPGA->host) endpoints.
//   fx2_state_t         : controller state encoding.
//   cnt_width()         : bits needed to hold a counter value 0..max_val.
package fx2_pkg;

  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP6_ADDR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN_RD,
    ST_RD,
    ST_TURN_WR,
    ST_WR,
    ST_PKTEND
  } fx2_state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fx2_out_buffer.sv
// fx2_out_buffer: 2-entry valid/ready FIFO between the FX2 read strobe and
// the host->FPGA output stream.
//   clk, rst_n  : clock, asynchronous active-low reset (contents dropped)
//   i_push      : write i_data this cycle (caller guarantees space)
//   i_data      : word captured from the FX2 data bus
//   i_ready     : downstream consumer accepts o_data
//   o_data      : head word
//   o_full      : both entries occupied
//   o_empty     : no entries occupied (o_data not valid)
module fx2_out_buffer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_pop;

  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = !o_empty && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/fx2_slavefifo_master.sv
// fx2_slavefifo_master: FPGA-side master for the FX2 synchronous slave FIFOs.
// EP2 words are read into a valid/ready output stream; input-stream words are
// written to EP6. Partial EP6 packets are committed with PKTEND after an idle
// timeout; full packets are auto-committed by the FX2.
//
// Ports:
//   clk, rst_n          : fx2_ifclk, asynchronous active-low reset
//   fx2_fd_in/out/oe    : FX2 data bus (sampled / driven / drive enable)
//   fx2_sloe/slrd/slwr  : active-low output enable, read and write strobes
//   fx2_pktend          : active-low packet end
//   fx2_fifoadr         : endpoint select (EP2 = 00, EP6 = 10)
//   fx2_flaga/flagb     : EP2 empty (0 = empty), EP6 full (0 = full)
//   out_data/valid/ready: host->FPGA stream
//   in_data/valid/ready : FPGA->host stream; in_ready == !fx2_slwr
//
// state    | meaning
// IDLE     | bus released, arbitrate read / write / flush
// TURN_RD  | FX2 starts driving the bus (SLOE low), no strobe yet
// RD       | read burst from EP2 into the out buffer
// TURN_WR  | FPGA starts driving the bus, no strobe yet
// WR       | write burst from the input stream to EP6
// PKTEND   | commit the partial EP6 packet
module fx2_slavefifo_master
  import fx2_pkg::*;
#(
  parameter int PKT_WORDS     = 256,
  parameter int FLUSH_TIMEOUT = 64,
  parameter int MAX_BURST     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] fx2_fd_in,
  output logic [15:0] fx2_fd_out,
  output logic        fx2_fd_oe,
  output logic        fx2_sloe,
  output logic        fx2_slrd,
  output logic        fx2_slwr,
  output logic        fx2_pktend,
  output logic [1:0]  fx2_fifoadr,
  input  logic        fx2_flaga,
  input  logic        fx2_flagb,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int PKT_W = cnt_width(PKT_WORDS - 1);
  localparam int FL_W  = cnt_width(FLUSH_TIMEOUT);
  localparam int BU_W  = cnt_width(MAX_BURST);

  fx2_state_t       r_state;
  fx2_state_t       w_next;
  logic [PKT_W-1:0] r_pkt_cnt;
  logic [FL_W-1:0]  r_flush_cnt;
  logic [BU_W-1:0]  r_burst_cnt;
  logic             r_last_rd;

  logic w_buf_full;
  logic w_buf_empty;
  logic w_buf_space;
  logic w_read_req;
  logic w_write_req;
  logic w_burst_max;
  logic w_flush_due;
  logic w_do_rd;
  logic w_do_wr;

  fx2_out_buffer #(.W(16)) u_out_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_do_rd),
    .i_data  (fx2_fd_in),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty)
  );

  assign out_valid = !w_buf_empty;

  // A full buffer still has room this cycle if its head is being consumed.
  assign w_buf_space = !w_buf_full || out_ready;
  assign w_read_req  = fx2_flaga && w_buf_space;
  assign w_write_req = in_valid && fx2_flagb;
  assign w_burst_max = (r_burst_cnt == BU_W'(MAX_BURST));
  assign w_flush_due = (r_flush_cnt == FL_W'(FLUSH_TIMEOUT)) && (r_pkt_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    fx2_sloe    = 1'b1;
    fx2_slrd    = 1'b1;
    fx2_slwr    = 1'b1;
    fx2_pktend  = 1'b1;
    fx2_fifoadr = EP2_ADDR;
    fx2_fd_oe   = 1'b0;
    fx2_fd_out  = '0;
    in_ready    = 1'b0;
    w_do_rd     = 1'b0;
    w_do_wr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_flush_due) begin
          w_next = ST_PKTEND;
        end else if (w_read_req && w_write_req) begin
          w_next = r_last_rd ? ST_TURN_WR : ST_TURN_RD;
        end else if (w_read_req) begin
          w_next = ST_TURN_RD;
        end else if (w_write_req) begin
          w_next = ST_TURN_WR;
        end
      end
      ST_TURN_RD: begin
        fx2_sloe = 1'b0;
        w_next   = ST_RD;
      end
      ST_RD: begin
        // SLOE is released in the exit cycle so IDLE already sees a quiet bus.
        if (!fx2_flaga || !w_buf_space || (w_burst_max && w_write_req)) begin
          w_next = ST_IDLE;
        end else begin
          fx2_sloe = 1'b0;
          fx2_slrd = 1'b0;
          w_do_rd  = 1'b1;
        end
      end
      ST_TURN_WR: begin
        fx2_fifoadr = EP6_ADDR;
        fx2_fd_oe   = 1'b1;
        w_next      = ST_WR;
      end
      ST_WR: begin
        fx2_fifoadr = EP6_ADDR;
        if (!w_write_req || (w_burst_max && w_read_req)) begin
          w_next = ST_IDLE;
        end else begin
          fx2_fd_oe  = 1'b1;
          fx2_fd_out = in_data;
          fx2_slwr   = 1'b0;
          in_ready   = 1'b1;
          w_do_wr    = 1'b1;
        end
      end
      ST_PKTEND: begin
        fx2_fifoadr = EP6_ADDR;
        fx2_pktend  = 1'b0;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt   <= '0;
      r_flush_cnt <= '0;
      r_burst_cnt <= '0;
      r_last_rd   <= 1'b0;
    end else begin
      if (r_state == ST_PKTEND) begin
        r_pkt_cnt <= '0;
      end else if (w_do_wr) begin
        // The FX2 commits a full packet on its own, so the count just wraps.
        r_pkt_cnt <= (r_pkt_cnt == PKT_W'(PKT_WORDS - 1)) ? '0 : r_pkt_cnt + 1'b1;
      end

      if (r_state == ST_PKTEND || w_do_wr) begin
        r_flush_cnt <= '0;
      end else if (r_pkt_cnt != '0 && r_flush_cnt != FL_W'(FLUSH_TIMEOUT)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end

      // Saturates at MAX_BURST: an uncontested burst simply keeps going.
      if (r_state == ST_TURN_RD || r_state == ST_TURN_WR) begin
        r_burst_cnt <= '0;
      end else if ((w_do_rd || w_do_wr) && !w_burst_max) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end

      if (r_state == ST_IDLE && w_next == ST_TURN_RD) begin
        r_last_rd <= 1'b1;
      end else if (r_state == ST_IDLE && w_next == ST_TURN_WR) begin
        r_last_rd <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fx2_slavefifo_master.sv
module tb_fx2_slavefifo_master;

  localparam int PKT_WORDS     = 256;
  localparam int FLUSH_TIMEOUT = 64;
  localparam int MAX_BURST     = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] fx2_fd_in = '0;
  logic [15:0] fx2_fd_out;
  logic        fx2_fd_oe;
  logic        fx2_sloe;
  logic        fx2_slrd;
  logic        fx2_slwr;
  logic        fx2_pktend;
  logic [1:0]  fx2_fifoadr;
  logic        fx2_flaga = 1'b0;
  logic        fx2_flagb = 1'b1;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;

  fx2_slavefifo_master #(
    .PKT_WORDS     (PKT_WORDS),
    .FLUSH_TIMEOUT (FLUSH_TIMEOUT),
    .MAX_BURST     (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fx2_fd_in   (fx2_fd_in),
    .fx2_fd_out  (fx2_fd_out),
    .fx2_fd_oe   (fx2_fd_oe),
    .fx2_sloe    (fx2_sloe),
    .fx2_slrd    (fx2_slrd),
    .fx2_slwr    (fx2_slwr),
    .fx2_pktend  (fx2_pktend),
    .fx2_fifoadr (fx2_fifoadr),
    .fx2_flaga   (fx2_flaga),
    .fx2_flagb   (fx2_flagb),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // FX2 endpoint and stream models
  logic [15:0] ep2_q[$];
  logic [15:0] in_q[$];
  logic [15:0] out_got[$];
  logic [15:0] ep6_got[$];
  bit          out_ready_en = 1'b0;
  bit          flagb_rand = 1'b0;

  int cyc = 0;
  int rd_total = 0, wr_total = 0, deliv_total = 0, pktend_total = 0;
  int last_wr_cyc = 0, last_pktend_cyc = 0;
  logic [1:0] last_pktend_addr = 2'b00;
  int words_since_commit = 0;
  int switches = 0;
  int v_strobe = 0, v_bus = 0, v_turn = 0, v_proto = 0, v_burst = 0, v_zlp = 0;

  logic s_sloe, s_slrd, s_slwr, s_pktend, s_fd_oe, s_in_ready, s_out_valid;
  logic s_flaga, s_flagb, s_in_valid, s_out_ready;
  logic [1:0]  s_fifoadr;
  logic [15:0] s_fd_out, s_out_data;
  logic p_fd_oe = 1'b0, p_sloe_low = 1'b0, p_pktend_low = 1'b0;
  int rd_run = 0, wr_run = 0, last_dir = 0;

  // Samples at the falling edge (inputs are stable there), applies the
  // endpoint side effects just after the rising edge.
  always begin : fx2_model
    int  nlow;
    int  occ;
    bit  rd_req;
    @(negedge clk);
    cyc++;
    s_sloe = fx2_sloe;  s_slrd = fx2_slrd;  s_slwr = fx2_slwr;  s_pktend = fx2_pktend;
    s_fd_oe = fx2_fd_oe;  s_fifoadr = fx2_fifoadr;  s_fd_out = fx2_fd_out;
    s_in_ready = in_ready;  s_out_valid = out_valid;  s_out_data = out_data;
    s_flaga = fx2_flaga;  s_flagb = fx2_flagb;  s_in_valid = in_valid;  s_out_ready = out_ready;
    if (rst_n) begin
      nlow = int'(!s_slrd) + int'(!s_slwr) + int'(!s_pktend);
      if (nlow > 1) v_strobe++;
      if (s_fd_oe && !s_sloe) v_bus++;
      if ((p_fd_oe && !s_sloe) || (p_sloe_low && s_fd_oe)) v_turn++;
      if (!s_slrd && (s_sloe || s_fd_oe || s_fifoadr != 2'b00 || !s_flaga)) v_proto++;
      if (!s_slwr && (!s_fd_oe || s_fifoadr != 2'b10 || !s_flagb)) v_proto++;
      if (!s_pktend && (s_fifoadr != 2'b10 || p_pktend_low)) v_proto++;
      if (s_in_ready !== !s_slwr) v_proto++;
      occ = rd_total - deliv_total;
      rd_req = s_flaga && (occ < 2 || s_out_ready);
      if (!s_slrd) begin
        if (rd_run >= MAX_BURST && s_in_valid && s_flagb) v_burst++;
        rd_run++;
        if (last_dir == 2) switches++;
        last_dir = 1;
      end
      if (!s_slwr) begin
        if (wr_run >= MAX_BURST && rd_req) v_burst++;
        wr_run++;
        if (last_dir == 1) switches++;
        last_dir = 2;
      end
      if (s_sloe) rd_run = 0;
      if (!s_fd_oe) wr_run = 0;
      p_fd_oe = s_fd_oe;  p_sloe_low = !s_sloe;  p_pktend_low = !s_pktend;
    end else begin
      p_fd_oe = 1'b0;  p_sloe_low = 1'b0;  p_pktend_low = 1'b0;
      rd_run = 0;  wr_run = 0;
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (!s_slrd) begin
        if (ep2_q.size() != 0) void'(ep2_q.pop_front());
        rd_total++;
      end
      if (s_in_ready && in_q.size() != 0) void'(in_q.pop_front());
      if (!s_slwr) begin
        ep6_got.push_back(s_fd_out);
        wr_total++;
        last_wr_cyc = cyc;
        words_since_commit = (words_since_commit + 1 == PKT_WORDS) ? 0 : words_since_commit + 1;
      end
      if (s_out_valid && s_out_ready) begin
        out_got.push_back(s_out_data);
        deliv_total++;
      end
      if (!s_pktend) begin
        pktend_total++;
        last_pktend_cyc = cyc;
        last_pktend_addr = s_fifoadr;
        if (words_since_commit == 0) v_zlp++;
        words_since_commit = 0;
      end
    end
    fx2_flaga = (ep2_q.size() != 0);
    fx2_fd_in = (ep2_q.size() != 0) ? ep2_q[0] : 16'h0000;
    fx2_flagb = flagb_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    in_valid  = (in_q.size() != 0);
    in_data   = (in_q.size() != 0) ? in_q[0] : 16'h0000;
    out_ready = out_ready_en;
  end

  function automatic int first_diff(input logic [15:0] a[$], input logic [15:0] b[$]);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ep2_q.push_back(16'hAAAA);
    in_q.push_back(16'h5555);
    wait_cyc(3);
    checks++;
    if ({fx2_sloe, fx2_slrd, fx2_slwr, fx2_pktend} !== 4'b1111) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 1111", {fx2_sloe, fx2_slrd, fx2_slwr, fx2_pktend});
    end
    checks++;
    if ({fx2_fd_oe, fx2_fifoadr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_oe_addr: got %b want 000", {fx2_fd_oe, fx2_fifoadr});
    end
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_stream: got valid/ready %b want 00", {out_valid, in_ready});
    end
    checks++;
    if (fx2_fd_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_fd_out: got %h want 0000", fx2_fd_out);
    end
    ep2_q.delete();
    in_q.delete();
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(4);
    checks++;
    if ({fx2_sloe, fx2_slrd, fx2_slwr, fx2_pktend, fx2_fd_oe} !== 5'b11110) begin
      errors++;
      $display("FAIL reset_idle: got %b want 11110", {fx2_sloe, fx2_slrd, fx2_slwr, fx2_pktend, fx2_fd_oe});
    end
  endtask

  task automatic test_read3;
    logic [15:0] exp[$];
    int base_rd;
    int d;
    exp = {16'h1111, 16'h2222, 16'h3333};
    out_got.delete();
    out_ready_en = 1'b1;
    base_rd = rd_total;
    foreach (exp[i]) ep2_q.push_back(exp[i]);
    for (int i = 0; i < 200 && out_got.size() < 3; i++) wait_cyc(1);
    wait_cyc(10);
    checks++;
    if (rd_total - base_rd != 3) begin
      errors++;
      $display("FAIL read3_pulses: got %0d slrd pulses want 3", rd_total - base_rd);
    end
    d = first_diff(out_got, exp);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL read3_data: got %0d words want 3, first bad index %0d", out_got.size(), d);
    end
    checks++;
    if ({fx2_sloe, fx2_slrd, fx2_fd_oe, out_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL read3_idle: got sloe/slrd/oe/valid %b want 1100", {fx2_sloe, fx2_slrd, fx2_fd_oe, out_valid});
    end
  endtask

  task automatic test_read_backpressure;
    logic [15:0] exp[$];
    int base_rd;
    int d;
    out_got.delete();
    out_ready_en = 1'b0;
    base_rd = rd_total;
    for (int i = 0; i < 10; i++) begin
      exp.push_back(16'($urandom));
      ep2_q.push_back(exp[i]);
    end
    wait_cyc(30);
    checks++;
    if (rd_total - base_rd != 2) begin
      errors++;
      $display("FAIL bp_stall: got %0d slrd pulses with out_ready low, want 2", rd_total - base_rd);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp[0]) begin
      errors++;
      $display("FAIL bp_head: got valid %b data %h want 1 %h", out_valid, out_data, exp[0]);
    end
    out_ready_en = 1'b1;
    for (int i = 0; i < 400 && out_got.size() < 10; i++) wait_cyc(1);
    wait_cyc(10);
    d = first_diff(out_got, exp);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL bp_data: got %0d words want 10, first bad index %0d", out_got.size(), d);
    end
    checks++;
    if (rd_total - base_rd != 10) begin
      errors++;
      $display("FAIL bp_pulses: got %0d slrd pulses want 10", rd_total - base_rd);
    end
  endtask

  task automatic test_full_packet;
    logic [15:0] exp[$];
    int base_wr, base_pe;
    int d;
    ep6_got.delete();
    base_wr = wr_total;
    base_pe = pktend_total;
    for (int i = 0; i < PKT_WORDS; i++) begin
      exp.push_back(16'($urandom));
      in_q.push_back(exp[i]);
    end
    for (int i = 0; i < 2000 && wr_total - base_wr < PKT_WORDS; i++) wait_cyc(1);
    wait_cyc(200);
    checks++;
    if (wr_total - base_wr != PKT_WORDS) begin
      errors++;
      $display("FAIL full_pulses: got %0d slwr pulses want %0d", wr_total - base_wr, PKT_WORDS);
    end
    d = first_diff(ep6_got, exp);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL full_data: got %0d words want %0d, first bad index %0d", ep6_got.size(), PKT_WORDS, d);
    end
    checks++;
    if (pktend_total != base_pe) begin
      errors++;
      $display("FAIL full_no_pktend: got %0d pktend pulses want 0", pktend_total - base_pe);
    end
  endtask

  task automatic test_short_packet;
    logic [15:0] exp[$];
    int base_wr, base_pe, lat;
    int d;
    ep6_got.delete();
    base_wr = wr_total;
    base_pe = pktend_total;
    for (int i = 0; i < 5; i++) begin
      exp.push_back(16'($urandom));
      in_q.push_back(exp[i]);
    end
    for (int i = 0; i < 200 && wr_total - base_wr < 5; i++) wait_cyc(1);
    wait_cyc(FLUSH_TIMEOUT + 80);
    d = first_diff(ep6_got, exp);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL short_data: got %0d words want 5, first bad index %0d", ep6_got.size(), d);
    end
    checks++;
    if (pktend_total - base_pe != 1) begin
      errors++;
      $display("FAIL short_pktend_count: got %0d want 1", pktend_total - base_pe);
    end
    // FLUSH_TIMEOUT idle cycles, plus up to two cycles to detect and commit.
    lat = last_pktend_cyc - last_wr_cyc;
    checks++;
    if (lat < FLUSH_TIMEOUT || lat > FLUSH_TIMEOUT + 2) begin
      errors++;
      $display("FAIL short_latency: got %0d cycles want %0d..%0d", lat, FLUSH_TIMEOUT, FLUSH_TIMEOUT + 2);
    end
    checks++;
    if (last_pktend_addr !== 2'b10) begin
      errors++;
      $display("FAIL short_addr: got %b want 10", last_pktend_addr);
    end
    wait_cyc(200);
    checks++;
    if (pktend_total - base_pe != 1) begin
      errors++;
      $display("FAIL short_single: got %0d pktend pulses want 1", pktend_total - base_pe);
    end
  endtask

  task automatic test_mixed;
    logic [15:0] exp_rd[$];
    logic [15:0] exp_wr[$];
    int d;
    out_got.delete();
    ep6_got.delete();
    switches = 0;
    out_ready_en = 1'b1;
    flagb_rand = 1'b1;
    for (int i = 0; i < 100; i++) begin
      exp_rd.push_back(16'($urandom));
      exp_wr.push_back(16'($urandom));
      ep2_q.push_back(exp_rd[i]);
      in_q.push_back(exp_wr[i]);
    end
    for (int i = 0; i < 5000 && (out_got.size() < 100 || ep6_got.size() < 100); i++) wait_cyc(1);
    flagb_rand = 1'b0;
    wait_cyc(FLUSH_TIMEOUT + 30);
    d = first_diff(out_got, exp_rd);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL mixed_rd_data: got %0d words want 100, first bad index %0d", out_got.size(), d);
    end
    d = first_diff(ep6_got, exp_wr);
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL mixed_wr_data: got %0d words want 100, first bad index %0d", ep6_got.size(), d);
    end
    checks++;
    if (switches < 2) begin
      errors++;
      $display("FAIL mixed_alternate: got %0d direction switches want >= 2", switches);
    end
    checks++;
    if (v_burst != 0) begin
      errors++;
      $display("FAIL mixed_burst_limit: got %0d over-long bursts want 0", v_burst);
    end
    checks++;
    if (words_since_commit != 0) begin
      errors++;
      $display("FAIL mixed_commit: got %0d uncommitted words want 0", words_since_commit);
    end
  endtask

  task automatic test_bus_rules;
    checks++;
    if (v_bus != 0) begin
      errors++;
      $display("FAIL bus_overlap: got %0d cycles with fd_oe and sloe active want 0", v_bus);
    end
    checks++;
    if (v_turn != 0) begin
      errors++;
      $display("FAIL bus_turnaround: got %0d missing turnarounds want 0", v_turn);
    end
    checks++;
    if (v_strobe != 0) begin
      errors++;
      $display("FAIL strobe_onehot: got %0d cycles with several strobes want 0", v_strobe);
    end
    checks++;
    if (v_proto != 0) begin
      errors++;
      $display("FAIL strobe_protocol: got %0d strobe/addr/ready violations want 0", v_proto);
    end
    checks++;
    if (v_zlp != 0) begin
      errors++;
      $display("FAIL zero_length_pkt: got %0d want 0", v_zlp);
    end
  endtask

  task automatic test_reset_mid;
    int base_wr, base_rd, base_pe;
    base_wr = wr_total;
    base_pe = pktend_total;
    out_ready_en = 1'b1;
    for (int i = 0; i < 3; i++) in_q.push_back(16'($urandom));
    for (int i = 0; i < 100 && wr_total - base_wr < 3; i++) wait_cyc(1);
    base_rd = rd_total;
    for (int i = 0; i < 10; i++) ep2_q.push_back(16'($urandom));
    for (int i = 0; i < 100 && rd_total - base_rd < 3; i++) wait_cyc(1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fx2_slrd, fx2_sloe, fx2_fd_oe, out_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL rstmid_async: got slrd/sloe/oe/valid %b want 1100", {fx2_slrd, fx2_sloe, fx2_fd_oe, out_valid});
    end
    ep2_q.delete();
    words_since_commit = 0;
    deliv_total = rd_total;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(FLUSH_TIMEOUT + 40);
    checks++;
    if (pktend_total != base_pe) begin
      errors++;
      $display("FAIL rstmid_pkt_cnt: got %0d pktend pulses after reset want 0", pktend_total - base_pe);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_buffer: got out_valid %b want 0", out_valid);
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_read3();
    test_read_backpressure();
    test_full_packet();
    test_short_packet();
    test_mixed();
    test_bus_rules();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
